gray_monitor: RTL and testbench
===============================

// Module: gray_monitor
// PURPOSE
//   Downstream consumer of the 3-bit gray counter (Clk/Reset/En -> Output, Overflow).
//   - Registers the gray value and decodes it to binary.
//   - Checks every step is a hold or a single forward increment.
//   - Counts wrap-arounds.
//   - Latches a sticky fault on any illegal step.
//   - Feeds status and debug logic in the same clock domain.
// PARAMETERS
//   WIDTH  3  gray code width; must match the upstream counter
//   CNT_W  8  width of the saturating wrap counter
// PORTS
//   Clk         in   1      system clock, rising edge
//   Reset       in   1      asynchronous, active-high reset
//   GrayIn      in   WIDTH  gray value from the upstream counter
//   ClrErr      in   1      synchronous fault clear and re-prime
//   BinOut      out  WIDTH  registered binary decode of GrayIn
//   Tracking    out  1      1 while the FSM is in TRACK
//   Wrap        out  1      one-cycle pulse on a step from all-ones to 0
//   WrapCnt     out  CNT_W  number of wraps, saturating at all-ones
//   StepErr     out  1      one-cycle pulse on an illegal step
//   ErrSticky   out  1      held at 1 from the first illegal step until ClrErr or Reset
// BEHAVIOUR
//   Reset (async, any time, including mid-operation):
//     - BinOut=0, Tracking=0, Wrap=0, WrapCnt=0, StepErr=0, ErrSticky=0.
//     - FSM goes to INIT.
//   Decode: b_new = gray2bin(GrayIn), where b[W-1]=g[W-1] and b[i]=b[i+1]^g[i].
//     Pure XOR chain; no arithmetic carry.
//   BinOut <= b_new on every edge in every state. Latency is 1 cycle.
//   Legal step: b_new == BinOut (hold), or b_new == BinOut+1 mod 2^WIDTH (increment).
//   FSM states: INIT, TRACK, FAULT.
//   INIT:
//     - Captures b_new with no check.
//     - Goes to TRACK on the next edge.
//     - Wrap and StepErr stay 0.
//   TRACK, legal step:
//     - Stays in TRACK.
//     - If BinOut==all-ones and b_new==0: Wrap<=1, and WrapCnt<=WrapCnt+1 unless already all-ones.
//     - Otherwise Wrap<=0.
//   TRACK, illegal step (backward, skip, multi-bit jump):
//     - StepErr<=1 for one cycle.
//     - ErrSticky<=1.
//     - Goes to FAULT.
//     - Wrap<=0 and WrapCnt is not incremented on that edge.
//   FAULT:
//     - No checks are made.
//     - WrapCnt is frozen and Wrap=0.
//     - BinOut keeps following GrayIn.
//     - Stays in FAULT until ClrErr.
//   ClrErr=1 at an edge (in any state):
//     - Has priority over the checks.
//     - Goes to INIT; StepErr<=0, ErrSticky<=0, Wrap<=0, WrapCnt<=0.
//     - BinOut still loads b_new.
//   Wrap and StepErr are mutually exclusive.
//   Wrap is never raised from the INIT capture.
//   Tracking = (state==TRACK). It is a registered-state decode.
//   A hold (upstream En=0) is always legal and leaves all counters unchanged.
// TESTING (WIDTH=3, CNT_W=8 unless stated)
//   1 Reset=1 then release; GrayIn=000 -> BinOut=0, Tracking=0 in cycle 1, Tracking=1 from cycle 2, no errors.
//   2 Feed 000,001,011,010,110,111,101,100,000 one per cycle -> BinOut 0..7 then 0; Wrap pulses once (7->0); WrapCnt=1; StepErr never set.
//   3 While tracking at 001, hold for 3 cycles -> no StepErr. Then 001->010 (bin 1->3) -> StepErr pulses 1 cycle, ErrSticky=1, Tracking=0, WrapCnt frozen through later wraps.
//   4 From 011 (bin 2) step to 001 (bin 1, backward) -> illegal. Then ClrErr=1 for 1 cycle with GrayIn=101 -> ErrSticky=0, WrapCnt=0, INIT. Then tracking resumes from bin 6 with no error.
//   5 CNT_W=2: drive 5 full cycles of the gray sequence -> WrapCnt goes 1, 2, 3, 3, 3 (saturates); Wrap pulses 5 times.
//   6 Assert Reset asynchronously between clock edges while WrapCnt=2 and ErrSticky=1 -> all outputs go to 0 immediately, without waiting for a clock edge; after release the FSM re-primes via INIT.

Source files
------------

// File: rtl/gray_monitor.sv
// rtl/gray_monitor.sv - registers and decodes a gray count, checks each step, counts wraps
// Steps must be a hold or a single forward increment; any other step latches a sticky fault.
module gray_monitor #(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] GrayIn,
  input  logic             ClrErr,
  output logic [WIDTH-1:0] BinOut,
  output logic             Tracking,
  output logic             Wrap,
  output logic [CNT_W-1:0] WrapCnt,
  output logic             StepErr,
  output logic             ErrSticky
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic               wrap_q, wrap_d;
  logic [CNT_W-1:0]   wrap_cnt_q, wrap_cnt_d;
  logic               step_err_q, step_err_d;
  logic               err_sticky_q, err_sticky_d;
  logic [WIDTH-1:0]   b_new;
  logic               step_legal;
  logic               step_wraps;

  // Each binary bit is the XOR of all gray bits at or above it.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      b_new[i] = ^(GrayIn >> i);
    end
  end

  assign step_legal = (b_new == bin_q) || (b_new == bin_q + WIDTH'(1));
  assign step_wraps = (bin_q == '1) && (b_new == '0);

  always_comb begin
    state_d      = state_q;
    bin_d        = b_new;
    wrap_d       = 1'b0;
    wrap_cnt_d   = wrap_cnt_q;
    step_err_d   = 1'b0;
    err_sticky_d = err_sticky_q;

    if (ClrErr) begin
      state_d      = ST_INIT;
      wrap_cnt_d   = '0;
      err_sticky_d = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: state_d = ST_TRACK;
        ST_TRACK: begin
          if (!step_legal) begin
            step_err_d   = 1'b1;
            err_sticky_d = 1'b1;
            state_d      = ST_FAULT;
          end else if (step_wraps) begin
            wrap_d = 1'b1;
            if (wrap_cnt_q != '1) begin
              wrap_cnt_d = wrap_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_INIT;
      bin_q        <= '0;
      wrap_q       <= 1'b0;
      wrap_cnt_q   <= '0;
      step_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      wrap_q       <= wrap_d;
      wrap_cnt_q   <= wrap_cnt_d;
      step_err_q   <= step_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign BinOut    = bin_q;
  assign Tracking  = (state_q == ST_TRACK);
  assign Wrap      = wrap_q;
  assign WrapCnt   = wrap_cnt_q;
  assign StepErr   = step_err_q;
  assign ErrSticky = err_sticky_q;

endmodule

// File: tb/tb_gray_monitor.sv
// tb/tb_gray_monitor.sv - randomized and directed bench for gray_monitor
// Two instances (CNT_W=8 and CNT_W=2) share one stimulus stream and one behavioural model.
module tb_gray_monitor;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [2:0] GrayIn = 3'd0;
  logic       ClrErr = 1'b0;

  logic [2:0] bin8, bin2;
  logic       trk8, trk2, wrap8, wrap2, err8, err2, st8, st2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  gray_monitor #(.WIDTH(3), .CNT_W(8)) dut8 (
    .Clk(Clk), .Reset(Reset), .GrayIn(GrayIn), .ClrErr(ClrErr),
    .BinOut(bin8), .Tracking(trk8), .Wrap(wrap8), .WrapCnt(cnt8),
    .StepErr(err8), .ErrSticky(st8)
  );

  gray_monitor #(.WIDTH(3), .CNT_W(2)) dut2 (
    .Clk(Clk), .Reset(Reset), .GrayIn(GrayIn), .ClrErr(ClrErr),
    .BinOut(bin2), .Tracking(trk2), .Wrap(wrap2), .WrapCnt(cnt2),
    .StepErr(err2), .ErrSticky(st2)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 = just primed/cleared, 1 = checking steps, 2 = faulted.
  int m_bin, m_phase, m_cnt;
  bit m_wrap, m_err, m_sticky;

  function automatic int b2g(int b);
    return (b ^ (b >> 1)) & 7;
  endfunction

  function automatic int g2b(int g);
    for (int b = 0; b < 8; b++) begin
      if (b2g(b) == g) return b;
    end
    return -1;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_bin = 0; m_phase = 0; m_cnt = 0;
      m_wrap = 0; m_err = 0; m_sticky = 0;
    end else begin
      int b, d;
      b = g2b(int'(GrayIn));
      d = (b - m_bin + 8) % 8;
      m_wrap = 0;
      m_err = 0;
      if (ClrErr) begin
        m_phase = 0; m_sticky = 0; m_cnt = 0;
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (d > 1) begin
          m_err = 1; m_sticky = 1; m_phase = 2;
        end else if (m_bin == 7 && b == 0) begin
          m_wrap = 1; m_cnt++;
        end
      end
      m_bin = b;
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("bin8", bin8, m_bin);
      chk("bin2", bin2, m_bin);
      chk("trk8", trk8, m_phase == 1);
      chk("trk2", trk2, m_phase == 1);
      chk("wrap8", wrap8, m_wrap);
      chk("wrap2", wrap2, m_wrap);
      chk("cnt8", cnt8, (m_cnt > 255) ? 255 : m_cnt);
      chk("cnt2", cnt2, (m_cnt > 3) ? 3 : m_cnt);
      chk("err8", err8, m_err);
      chk("err2", err2, m_err);
      chk("sticky8", st8, m_sticky);
      chk("sticky2", st2, m_sticky);
    end
  end

  task automatic drive(int g, bit clr);
    GrayIn = 3'(g);
    ClrErr = clr;
    @(posedge Clk);
    #1;
  endtask

  task automatic full_cycle();
    for (int b = 1; b <= 8; b++) drive(b2g(b % 8), 1'b0);
  endtask

  initial begin
    int cur;
    #1 Reset = 1'b1;
    chk_en = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #1 Reset = 1'b0;
    chk("rst_bin", bin8, 0);
    chk("rst_trk_c1", trk8, 0);
    drive(0, 0);
    chk("trk_c2", trk8, 1);
    chk("rst_err", err8, 0);

    for (int b = 1; b <= 8; b++) begin
      drive(b2g(b % 8), 0);
      chk("seq_bin", bin8, b % 8);
      chk("seq_wrap", wrap8, b == 8);
    end
    chk("seq_cnt", cnt8, 1);

    drive(3'b001, 0);
    for (int i = 0; i < 3; i++) begin
      drive(3'b001, 0);
      chk("hold_err", err8, 0);
    end
    drive(3'b010, 0);
    chk("skip_err", err8, 1);
    chk("skip_sticky", st8, 1);
    chk("skip_trk", trk8, 0);
    drive(3'b010, 0);
    chk("skip_err_pulse", err8, 0);
    for (int b = 4; b <= 8; b++) drive(b2g(b % 8), 0);
    full_cycle();
    chk("fault_frozen", cnt8, 1);
    chk("fault_sticky", st8, 1);

    drive(3'b000, 1);
    drive(3'b000, 0);
    drive(3'b001, 0);
    drive(3'b011, 0);
    drive(3'b001, 0);
    chk("back_err", err8, 1);
    drive(3'b101, 1);
    chk("clr_sticky", st8, 0);
    chk("clr_cnt", cnt8, 0);
    chk("clr_trk", trk8, 0);
    chk("clr_bin", bin8, 6);
    drive(3'b101, 0);
    chk("resume_trk", trk8, 1);
    drive(3'b100, 0);
    drive(3'b000, 0);
    chk("resume_wrap", wrap8, 1);
    chk("resume_err", err8, 0);

    drive(0, 1);
    drive(0, 0);
    for (int c = 1; c <= 5; c++) begin
      full_cycle();
      chk("sat_cnt2", cnt2, (c > 3) ? 3 : c);
      chk("sat_cnt8", cnt8, c);
      chk("sat_wrap2", wrap2, 1);
    end

    cur = 0;
    for (int i = 0; i < 400; i++) begin
      int r;
      bit clr;
      r = $urandom_range(0, 99);
      clr = 1'b0;
      if (r < 35) begin
      end else if (r < 85) begin
        cur = (cur + 1) % 8;
      end else if (r < 95) begin
        cur = $urandom_range(0, 7);
      end else begin
        cur = $urandom_range(0, 7);
        clr = 1'b1;
      end
      drive(b2g(cur), clr);
    end

    drive(0, 1);
    drive(0, 0);
    full_cycle();
    full_cycle();
    drive(b2g(3), 0);
    chk("pre_rst_cnt", cnt8, 2);
    chk("pre_rst_sticky", st8, 1);
    #2 Reset = 1'b1;
    #1;
    chk("arst_bin", bin8, 0);
    chk("arst_cnt", cnt8, 0);
    chk("arst_sticky", st8, 0);
    chk("arst_trk", trk8, 0);
    chk("arst_cnt2", cnt2, 0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    GrayIn = 3'(b2g(5));
    #1;
    chk("arst_init", trk8, 0);
    drive(b2g(5), 0);
    chk("arst_reprime", trk8, 1);
    chk("arst_reprime_bin", bin8, 5);
    drive(b2g(6), 0);
    chk("arst_no_err", err8, 0);

    @(negedge Clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
